// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: three-stage IEEE-754 add/subtract (align, add, normalise/round)
// with a valid/ready handshake; the whole pipe stalls on output backpressure.
// Subnormal inputs and results are flushed to signed zero; rounding is RNE.
// Optional build macro FP_ADD_FLAGS_EN adds the registered FLAGS output
// {invalid, overflow, underflow, inexact}.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [EXP_W+MAN_W:0] OP_A,
    input  logic [EXP_W+MAN_W:0] OP_B,
    input  logic                 OP,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [EXP_W+MAN_W:0] IEEE_FORMAT
`ifdef FP_ADD_FLAGS_EN
   ,output logic [3:0]           FLAGS
`endif
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int AW  = MAN_W + 3;           // hidden, mantissa, guard, round
    localparam int SW  = MAN_W + 4;           // AW plus sticky
    localparam int LZW = $clog2(SW + 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [EXP_W+1:0] E_INF = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [EXP_W+1:0] E_ONE = {{(EXP_W+1){1'b0}}, 1'b1};

    logic adv;
    assign adv      = ~OUT_VALID | OUT_READY;
    assign IN_READY = adv;

    // ---------------- stage 1: unpack, classify, swap, align ----------------
    logic                 a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [EXP_W-1:0]     a_exp, b_exp, l_exp, s_exp, exp_diff, shamt;
    logic [MAN_W-1:0]     a_man, b_man, l_man, s_man;
    logic [EXP_W+MAN_W-1:0] a_mag, b_mag;
    logic                 swap, l_sign, s_sign, l_zero, s_zero;
    logic [MAN_W:0]       l_sig, s_sig;
    logic [2*AW-1:0]      sh;
    logic                 al_spec;
    logic [W-1:0]         al_spec_val;
`ifdef FP_ADD_FLAGS_EN
    logic                 al_inv;
`endif

    // Operand unpack, special-case detection and alignment of the smaller operand
    always_comb begin
        a_sign = OP_A[W-1];
        a_exp  = OP_A[W-2:MAN_W];
        a_man  = OP_A[MAN_W-1:0];
        b_sign = OP_B[W-1] ^ OP;
        b_exp  = OP_B[W-2:MAN_W];
        b_man  = OP_B[MAN_W-1:0];

        a_zero = (a_exp == '0);
        b_zero = (b_exp == '0);
        a_inf  = (a_exp == '1) && (a_man == '0);
        b_inf  = (b_exp == '1) && (b_man == '0);
        a_nan  = (a_exp == '1) && (a_man != '0);
        b_nan  = (b_exp == '1) && (b_man != '0);

        // subnormals compare as zero
        a_mag = a_zero ? '0 : {a_exp, a_man};
        b_mag = b_zero ? '0 : {b_exp, b_man};
        swap  = (b_mag > a_mag);

        l_sign = swap ? b_sign : a_sign;
        l_exp  = swap ? b_exp  : a_exp;
        l_man  = swap ? b_man  : a_man;
        l_zero = swap ? b_zero : a_zero;
        s_sign = swap ? a_sign : b_sign;
        s_exp  = swap ? a_exp  : b_exp;
        s_man  = swap ? a_man  : b_man;
        s_zero = swap ? a_zero : b_zero;

        l_sig = {~l_zero, l_zero ? {MAN_W{1'b0}} : l_man};
        s_sig = {~s_zero, s_zero ? {MAN_W{1'b0}} : s_man};

        // shifting by AW or more pushes everything into the sticky half
        exp_diff = l_exp - s_exp;
        shamt    = (32'(exp_diff) > 32'(AW)) ? EXP_W'(AW) : exp_diff;
        sh       = {s_sig, 2'b00, {AW{1'b0}}} >> shamt;

        al_spec     = a_nan | b_nan | a_inf | b_inf;
        al_spec_val = '0;
`ifdef FP_ADD_FLAGS_EN
        al_inv = 1'b0;
`endif
        if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
            al_spec_val = QNAN;
`ifdef FP_ADD_FLAGS_EN
            // quiet bit clear marks a signalling NaN
            al_inv = (a_nan && !a_man[MAN_W-1]) || (b_nan && !b_man[MAN_W-1]) ||
                     (a_inf && b_inf);
`endif
        end else if (a_inf) begin
            al_spec_val = {a_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            al_spec_val = {b_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    logic             s1_valid, s1_sign, s1_sub, s1_zsign, s1_sticky, s1_spec;
    logic [EXP_W-1:0] s1_exp;
    logic [AW-1:0]    s1_lman, s1_sman;
    logic [W-1:0]     s1_spec_val;
`ifdef FP_ADD_FLAGS_EN
    logic             s1_inv;
`endif

    // Stage 1 register; an exact-zero sum keeps the sign only when both operands share it
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_sub      <= 1'b0;
            s1_zsign    <= 1'b0;
            s1_sticky   <= 1'b0;
            s1_spec     <= 1'b0;
            s1_exp      <= '0;
            s1_lman     <= '0;
            s1_sman     <= '0;
            s1_spec_val <= '0;
`ifdef FP_ADD_FLAGS_EN
            s1_inv      <= 1'b0;
`endif
        end else if (adv) begin
            s1_valid    <= IN_VALID;
            s1_sign     <= l_sign;
            s1_sub      <= l_sign ^ s_sign;
            s1_zsign    <= l_sign & s_sign;
            s1_sticky   <= |sh[AW-1:0];
            s1_spec     <= al_spec;
            s1_exp      <= l_exp;
            s1_lman     <= {l_sig, 2'b00};
            s1_sman     <= sh[2*AW-1:AW];
            s1_spec_val <= al_spec_val;
`ifdef FP_ADD_FLAGS_EN
            s1_inv      <= al_inv;
`endif
        end
    end

    // ---------------- stage 2: magnitude add / subtract ----------------
    logic [SW:0] l_ext, s_ext, sum;

    // Sticky sits in the LSB so a borrow through it rounds correctly
    always_comb begin
        l_ext = {1'b0, s1_lman, 1'b0};
        s_ext = {1'b0, s1_sman, s1_sticky};
        sum   = s1_sub ? (l_ext - s_ext) : (l_ext + s_ext);
    end

    logic             s2_valid, s2_sign, s2_zsign, s2_spec;
    logic [EXP_W-1:0] s2_exp;
    logic [SW:0]      s2_sum;
    logic [W-1:0]     s2_spec_val;
`ifdef FP_ADD_FLAGS_EN
    logic             s2_inv;
`endif

    // Stage 2 register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s2_valid    <= 1'b0;
            s2_sign     <= 1'b0;
            s2_zsign    <= 1'b0;
            s2_spec     <= 1'b0;
            s2_exp      <= '0;
            s2_sum      <= '0;
            s2_spec_val <= '0;
`ifdef FP_ADD_FLAGS_EN
            s2_inv      <= 1'b0;
`endif
        end else if (adv) begin
            s2_valid    <= s1_valid;
            s2_sign     <= s1_sign;
            s2_zsign    <= s1_zsign;
            s2_spec     <= s1_spec;
            s2_exp      <= s1_exp;
            s2_sum      <= sum;
            s2_spec_val <= s1_spec_val;
`ifdef FP_ADD_FLAGS_EN
            s2_inv      <= s1_inv;
`endif
        end
    end

    // ---------------- stage 3: normalise, round, pack ----------------
    function automatic logic [LZW-1:0] lead_zeros(input logic [SW-1:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = '0;
        found = 1'b0;
        for (int i = SW - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + LZW'(1);
            end
        end
        return n;
    endfunction

    logic [LZW-1:0]          lz;
    logic [SW-1:0]           norm;
    logic signed [EXP_W+1:0] e_base, e_norm, e_rnd;
    logic                    rnd_up;
    logic [MAN_W+1:0]        mant_r;
    logic [MAN_W-1:0]        man_out;
    logic [W-1:0]            res;
`ifdef FP_ADD_FLAGS_EN
    logic [3:0]              res_flags;
`endif

    // Normalise on carry or leading zeros, round to nearest even, then range-check
    always_comb begin
        lz     = lead_zeros(s2_sum[SW-1:0]);
        e_base = $signed({2'b00, s2_exp});
        if (s2_sum[SW]) begin
            norm   = {s2_sum[SW:2], s2_sum[1] | s2_sum[0]};
            e_norm = e_base + E_ONE;
        end else begin
            norm   = s2_sum[SW-1:0] << lz;
            e_norm = e_base - $signed((EXP_W+2)'(lz));
        end
        rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r  = {1'b0, norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
        e_rnd   = mant_r[MAN_W+1] ? (e_norm + E_ONE) : e_norm;
        man_out = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];

`ifdef FP_ADD_FLAGS_EN
        res_flags = 4'b0000;
`endif
        if (s2_spec) begin
            res = s2_spec_val;
`ifdef FP_ADD_FLAGS_EN
            res_flags = {s2_inv, 3'b000};
`endif
        end else if (s2_sum == '0) begin
            res = {s2_zsign, {(W-1){1'b0}}};
        end else if (e_rnd >= E_INF) begin
            res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_ADD_FLAGS_EN
            res_flags = 4'b0101;
`endif
        end else if (e_rnd < E_ONE) begin
            res = {s2_sign, {(W-1){1'b0}}};
`ifdef FP_ADD_FLAGS_EN
            res_flags = 4'b0011;
`endif
        end else begin
            res = {s2_sign, e_rnd[EXP_W-1:0], man_out};
`ifdef FP_ADD_FLAGS_EN
            res_flags = {3'b000, norm[2] | norm[1] | norm[0]};
`endif
        end
    end

    // Output register; holds while downstream is not ready
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            OUT_VALID   <= 1'b0;
            IEEE_FORMAT <= '0;
`ifdef FP_ADD_FLAGS_EN
            FLAGS       <= 4'b0000;
`endif
        end else if (adv) begin
            OUT_VALID   <= s2_valid;
            IEEE_FORMAT <= res;
`ifdef FP_ADD_FLAGS_EN
            FLAGS       <= res_flags;
`endif
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed vectors for fp_addsub_pipe (single precision),
// plus streaming-with-stall and mid-flight reset sequences.
module tb_fp_addsub_pipe;

    logic        CLK, RST, IN_VALID, IN_READY, OP, OUT_VALID, OUT_READY;
    logic [31:0] OP_A, OP_B, IEEE_FORMAT;
`ifdef FP_ADD_FLAGS_EN
    logic [3:0]  FLAGS;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    vec_t        vecs [21];
    logic [31:0] s_a  [8];
    logic [31:0] s_e  [8];

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .OP_A        (OP_A),
        .OP_B        (OP_B),
        .OP          (OP),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .IEEE_FORMAT (IEEE_FORMAT)
`ifdef FP_ADD_FLAGS_EN
       ,.FLAGS       (FLAGS)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one vector into an empty pipe and confirm the 3-cycle latency
    task automatic run_vec(input vec_t v, input int idx);
        @(negedge CLK);
        OP_A = v.a; OP_B = v.b; OP = v.op; IN_VALID = 1'b1; OUT_READY = 1'b1;
        #1 check($sformatf("vec%0d in_ready", idx), 32'(IN_READY), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        IN_VALID = 1'b0;
        #1 check($sformatf("vec%0d valid_c1", idx), 32'(OUT_VALID), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        #1 check($sformatf("vec%0d valid_c2", idx), 32'(OUT_VALID), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        #1 check($sformatf("vec%0d valid_c3", idx), 32'(OUT_VALID), 32'd1);
        check($sformatf("vec%0d result", idx), IEEE_FORMAT, v.res);
`ifdef FP_ADD_FLAGS_EN
        check($sformatf("vec%0d flags", idx), 32'(FLAGS), 32'(v.flg));
`endif
    endtask

    initial begin
        int  sent, recv, stall_seen;
        logic in_fire;

        //            a             b             op    result        {inv,ovf,unf,inx}
        vecs[0]  = '{32'h3EE00000, 32'h3EE00000, 1'b0, 32'h3F600000, 4'b0000};
        vecs[1]  = '{32'h3F000000, 32'hBEE00000, 1'b0, 32'h3D800000, 4'b0000};
        vecs[2]  = '{32'hBF000000, 32'h3EE00000, 1'b0, 32'hBD800000, 4'b0000};
        vecs[3]  = '{32'hBEE00000, 32'hBF000000, 1'b0, 32'hBF700000, 4'b0000};
        vecs[4]  = '{32'h3EE00000, 32'h3EE00000, 1'b1, 32'h00000000, 4'b0000};
        vecs[5]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
        vecs[6]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};
        vecs[7]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
        vecs[8]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000};
        vecs[9]  = '{32'h00400000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000};
        vecs[10] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
        vecs[11] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000};
        vecs[12] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000};
        vecs[13] = '{32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 4'b0000};
        vecs[14] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000};
        vecs[15] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000};
        vecs[16] = '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 4'b0000};
        vecs[17] = '{32'h80C00000, 32'h00800000, 1'b0, 32'h80000000, 4'b0011};
        vecs[18] = '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001};
        vecs[19] = '{32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000};
        vecs[20] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000};

        // stream: (i+1) + 1.0 = i+2
        s_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        s_e = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

        RST = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; OP = 1'b0;
        OP_A = '0; OP_B = '0;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("reset out_valid", 32'(OUT_VALID), 32'd0);
        check("reset result", IEEE_FORMAT, 32'h0);
        check("reset in_ready", 32'(IN_READY), 32'd1);
`ifdef FP_ADD_FLAGS_EN
        check("reset flags", 32'(FLAGS), 32'd0);
`endif
        @(negedge CLK);
        RST = 1'b1;

        for (int i = 0; i < 21; i++) run_vec(vecs[i], i);

        // back-to-back stream with a 4-cycle output stall
        sent = 0; recv = 0; stall_seen = 0;
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            @(negedge CLK);
            OUT_READY = !(cyc >= 4 && cyc < 8);
            if (sent < 8) begin
                IN_VALID = 1'b1; OP_A = s_a[sent]; OP_B = 32'h3F800000; OP = 1'b0;
            end else begin
                IN_VALID = 1'b0;
            end
            #1;
            if (!OUT_READY) begin
                stall_seen++;
                check($sformatf("stall c%0d out_valid", cyc), 32'(OUT_VALID), 32'd1);
                check($sformatf("stall c%0d in_ready", cyc), 32'(IN_READY), 32'd0);
            end
            if (OUT_VALID && OUT_READY) begin
                check($sformatf("stream item%0d", recv), IEEE_FORMAT, s_e[recv]);
                recv++;
            end
            in_fire = IN_VALID && IN_READY;
            @(posedge CLK);
            if (in_fire) sent++;
        end
        check("stream received count", 32'(recv), 32'd8);
        check("stream stall cycles", 32'(stall_seen), 32'd4);

        // reset with three results in flight
        @(negedge CLK);
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            IN_VALID = 1'b1; OP_A = s_a[i]; OP_B = 32'h3F800000; OP = 1'b0;
            @(posedge CLK);
        end
        @(negedge CLK);
        IN_VALID = 1'b0;
        #1 check("inflight out_valid", 32'(OUT_VALID), 32'd1);
        RST = 1'b0;
        #1;
        check("midreset out_valid", 32'(OUT_VALID), 32'd0);
        check("midreset result", IEEE_FORMAT, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1 check($sformatf("post-reset idle c%0d", i), 32'(OUT_VALID), 32'd0);
        end
        run_vec(vecs[0], 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
